inter_pred_blk_sched: RTL and testbench
=======================================

Name: inter_pred_blk_sched

Overview:
- Block scheduler for the inter-prediction interpolation datapath.
- Pops one reference-patch word per 4x4 block from the ref-pixel FIFO and issues 4 row-slots per block.
- Carries per-block fractional MV and chroma-plane tags through a parametrised delay pipeline.
- Generates the 16-lane output-RAM write enables, write address and read address.
- Successor to the fixed 5-stage scheduler:
  - configurable pipeline depth and MV fraction width;
  - optional chroma (monochrome mode);
  - back-to-back block issue with no bubble;
  - done/busy handshake.

Parameters:
- PPL_DEPTH, 4: number of delay stages between row issue and the stage-out outputs (1..8).
- MV_W, 3: fractional MV bits carried per component.
- CHROMA_EN, 1: 1 means 24 blocks per MB (16 luma, 4 Cb, 4 Cr); 0 means 16 luma blocks only.
- AW, 5: output-RAM address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  global enable; low freezes all state
- start  in  1  MB start pulse; honoured only in IDLE
- start_of_MB  in  1  clears out_ram_rd_addr
- col_sel  in  1  0 means row-wise lane mapping; 1 means column-wise lane mapping
- mvx_frac  in  16*MV_W  fractional MVx per raster 4x4 block; block i at [i*MV_W +: MV_W]
- mvy_frac  in  16*MV_W  fractional MVy, same packing as mvx_frac
- ref_fifo_empty  in  1  ref-pixel FIFO empty
- ref_fifo_rd  out  1  FIFO pop, combinational
- busy  out  1  high outside IDLE
- done  out  1  1-cycle pulse when the last row of the MB leaves the pipeline
- so_vld  out  1  stage-out row valid
- so_row  out  2  row index within block
- so_blk  out  5  block index 0..23
- so_fx  out  MV_W  fractional x
- so_fy  out  MV_W  fractional y
- so_cb  out  1  Cb tag
- so_cr  out  1  Cr tag
- out_ram_wr  out  16  per-lane write enables
- out_ram_wr_addr  out  AW  write address
- out_ram_rd  in  1  read strobe
- out_ram_rd_addr  out  AW  read address

Behaviour:
- Reset values: every register and output is 0; state is IDLE.
- ena=0: state, counters and pipeline hold; ref_fifo_rd=0; out_ram_wr=0; done=0.
- Block count: NB = CHROMA_EN ? 24 : 16. Counters blk (5b) and row (2b).
- FSM:
  - IDLE: on start, latch mvx_frac and mvy_frac, blk=0, go to WAIT.
  - WAIT: if !ref_fifo_empty, ref_fifo_rd=1, row=0, go to ISSUE.
  - ISSUE: each cycle issue slot (blk,row) into pipeline stage 0, then row++.
    - At row==3 with blk<NB-1: blk++. If !ref_fifo_empty, ref_fifo_rd=1, row=0, stay in ISSUE (no bubble). Otherwise go to WAIT.
    - At row==3 with blk==NB-1: go to DRAIN.
  - DRAIN: wait until pipeline empty, pulse done, go to IDLE.
- start while busy is ignored. start in the same cycle as the last DRAIN cycle is also ignored.
- MV select:
  - blk<16: use raster entry blk.
  - blk 16..23: quadrant q=(blk-16)%4 uses raster entry {0,2,8,10}[q].
- Chroma tags: so_cb=1 for blk 16..19; so_cr=1 for blk 20..23.
- Pipeline: PPL_DEPTH registers of {vld,row,blk,fx,fy,cb,cr}. Shifts every ena cycle; vld=0 on non-issue cycles. Stage-out latency from issue is exactly PPL_DEPTH cycles.
- Write enables, only when so_vld:
  - col_sel=0: out_ram_wr[so_row*4 +: 4] = 4'hF.
  - col_sel=1: bits so_row, so_row+4, so_row+8 and so_row+12 are set.
- out_ram_wr_addr: combinational from so_blk.
  - Luma raster 0..15 maps to Z-order: 0 1 4 5 / 2 3 6 7 / 8 9 12 13 / 10 11 14 15.
  - Chroma blocks 16..23 map to themselves.
- out_ram_rd_addr: out_ram_rd gives +1, wrapping at 2^AW. Else start_of_MB gives 0. out_ram_rd has priority over start_of_MB.
- Reset asserted mid-MB: immediate return to IDLE with the pipeline cleared. No done pulse.

Decomposition:
- Shared package inter_pred_pkg holds:
  - FSM state encodings (IDLE, WAIT, ISSUE, DRAIN);
  - NB_LUMA=16 and NB_CHROMA=8;
  - the raster-to-Z-order address function;
  - the chroma quadrant-to-raster constant table.
- One natural sub-module, inter_pred_tag_pipe: parametrised delay line of the tag bundle with a per-stage valid bit.

Test Plan:
- FIFO never empty, CHROMA_EN=1, PPL_DEPTH=4, col_sel=0:
  - 96 consecutive issue cycles and 24 pops;
  - so_vld first seen 4 cycles after the first issue;
  - done 1 cycle after the last so_vld;
  - blk 3 row 2 gives out_ram_wr=16'h0F00 and out_ram_wr_addr=5.
- Empty FIFO for 3 cycles after block 5:
  - state goes to WAIT;
  - no issue and no ref_fifo_rd during the stall;
  - block 6 resumes at row 0;
  - total pops remain 24.
- col_sel=1, blk 0 row 1 -> out_ram_wr=16'h2222.
- Chroma blocks: mvx_frac entry 8 = 3'd5 -> blk 18 and blk 22 carry so_fx=5; blk 18 has so_cb=1, blk 22 has so_cr=1.
- CHROMA_EN=0 -> exactly 64 issue slots and 16 pops, then done. start pulsed during ISSUE is ignored.
- Control corner cases:
  - ena held low for 5 cycles mid-block freezes all outputs;
  - rst_n asserted mid-block clears busy, so_vld and the address counters immediately;
  - out_ram_rd and start_of_MB in the same cycle with rd_addr=7 gives rd_addr=8.

Source files
------------

// File: rtl/inter_pred_pkg.sv
// Shared definitions for the inter-prediction block scheduler.
//   - scheduler FSM state encoding
//   - luma/chroma block counts per macroblock
//   - raster-to-Z-order output-RAM address mapping
//   - chroma quadrant to luma-raster MV source table
package inter_pred_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_DRAIN = 2'd3
   } sched_state_e;

   localparam int NB_LUMA   = 16;
   localparam int NB_CHROMA = 8;

   // Chroma blocks reuse the MV of the top-left luma block of their quadrant.
   // Entry q occupies bits [q*4 +: 4]: quadrants 0..3 -> raster 0, 2, 8, 10.
   localparam logic [15:0] CHROMA_SRC_TBL = {4'd10, 4'd8, 4'd2, 4'd0};

   // Luma raster index {row[1:0], col[1:0]} becomes Z-order {row1, col1, row0, col0}.
   // Chroma blocks keep their own index.
   function automatic logic [4:0] blk_to_addr(input logic [4:0] blk);
      if (blk < 5'(NB_LUMA)) begin
         return {1'b0, blk[3], blk[1], blk[2], blk[0]};
      end
      return blk;
   endfunction

   // Raster entry of the MV arrays used by a given block index.
   // Chroma blocks start at 16, so (blk-16)%4 is simply blk[1:0].
   function automatic logic [3:0] mv_src_idx(input logic [4:0] blk);
      if (blk < 5'(NB_LUMA)) begin
         return blk[3:0];
      end
      return CHROMA_SRC_TBL[{blk[1:0], 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/inter_pred_tag_pipe.sv
// Delay line for the per-row tag bundle, one valid bit per stage.
//   clk, rst_n : clock, async active-low reset
//   ena        : shift enable; low holds every stage
//   vld_i/tag_i: entry into stage 0
//   vld_o/tag_o: last stage
//   busy_o     : any stage holds a valid entry
module inter_pred_tag_pipe
   import inter_pred_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic         vld_i,
   input  logic [W-1:0] tag_i,
   output logic         vld_o,
   output logic [W-1:0] tag_o,
   output logic         busy_o
);

   logic [DEPTH-1:0] vld_q;
   logic [W-1:0]     tag_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i] <= '0;
         end
      end else if (ena) begin
         vld_q[0] <= vld_i;
         tag_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign vld_o  = vld_q[DEPTH-1];
   assign tag_o  = tag_q[DEPTH-1];
   assign busy_o = |vld_q;

endmodule

// File: rtl/inter_pred_blk_sched.sv
// Block scheduler for the inter-prediction interpolation datapath.
// Pops one reference-patch word per 4x4 block, issues four row slots per block
// into a tag delay pipe and turns the stage-out tags into output-RAM strobes.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   ena                    global enable; low freezes all state
//   start, start_of_MB     MB start (honoured in IDLE), read-address clear
//   col_sel                0 row-wise lane mapping, 1 column-wise
//   mvx_frac, mvy_frac     fractional MVs per raster 4x4 block
//   ref_fifo_empty/_rd     ref-pixel FIFO status / pop
//   busy, done             handshake
//   so_*                   stage-out row tags
//   out_ram_wr/_wr_addr    16-lane write enables and address
//   out_ram_rd/_rd_addr    read strobe and read address counter
//
// state    | meaning
// ST_IDLE  | waiting for start, MVs latched on start
// ST_WAIT  | block pending, waiting for a ref-FIFO word
// ST_ISSUE | issuing one row slot per cycle
// ST_DRAIN | all slots issued, waiting for the pipe to empty
module inter_pred_blk_sched
   import inter_pred_pkg::*;
#(
   parameter int PPL_DEPTH = 4,
   parameter int MV_W      = 3,
   parameter int CHROMA_EN = 1,
   parameter int AW        = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               start,
   input  logic               start_of_MB,
   input  logic               col_sel,
   input  logic [16*MV_W-1:0] mvx_frac,
   input  logic [16*MV_W-1:0] mvy_frac,
   input  logic               ref_fifo_empty,
   output logic               ref_fifo_rd,
   output logic               busy,
   output logic               done,
   output logic               so_vld,
   output logic [1:0]         so_row,
   output logic [4:0]         so_blk,
   output logic [MV_W-1:0]    so_fx,
   output logic [MV_W-1:0]    so_fy,
   output logic               so_cb,
   output logic               so_cr,
   output logic [15:0]        out_ram_wr,
   output logic [AW-1:0]      out_ram_wr_addr,
   input  logic               out_ram_rd,
   output logic [AW-1:0]      out_ram_rd_addr
);

   localparam int         NB       = (CHROMA_EN != 0) ? NB_LUMA + NB_CHROMA : NB_LUMA;
   localparam logic [4:0] LAST_BLK = 5'(NB - 1);
   localparam int         TAG_W    = 2 + 5 + 2*MV_W + 2;

   sched_state_e       state_q, state_d;
   logic [4:0]         blk_q, blk_d;
   logic [1:0]         row_q, row_d;
   logic [16*MV_W-1:0] mvx_q, mvx_d;
   logic [16*MV_W-1:0] mvy_q, mvy_d;
   logic [AW-1:0]      rd_addr_q, rd_addr_d;

   logic               issue;
   logic               pipe_busy;
   logic [3:0]         src_idx;
   logic [MV_W-1:0]    fx_sel, fy_sel;
   logic               cb_sel, cr_sel;
   logic [TAG_W-1:0]   tag_in, tag_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         blk_q     <= '0;
         row_q     <= '0;
         mvx_q     <= '0;
         mvy_q     <= '0;
         rd_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         blk_q     <= blk_d;
         row_q     <= row_d;
         mvx_q     <= mvx_d;
         mvy_q     <= mvy_d;
         rd_addr_q <= rd_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      blk_d       = blk_q;
      row_d       = row_q;
      mvx_d       = mvx_q;
      mvy_d       = mvy_q;
      issue       = 1'b0;
      ref_fifo_rd = 1'b0;
      done        = 1'b0;
      if (ena) begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  mvx_d   = mvx_frac;
                  mvy_d   = mvy_frac;
                  blk_d   = '0;
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!ref_fifo_empty) begin
                  ref_fifo_rd = 1'b1;
                  row_d       = '0;
                  state_d     = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               issue = 1'b1;
               row_d = row_q + 2'd1;
               if (row_q == 2'd3) begin
                  if (blk_q != LAST_BLK) begin
                     blk_d = blk_q + 5'd1;
                     // next block's word already available: keep issuing, row wraps to 0
                     if (!ref_fifo_empty) begin
                        ref_fifo_rd = 1'b1;
                     end else begin
                        state_d = ST_WAIT;
                     end
                  end else begin
                     state_d = ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (!pipe_busy) begin
                  done    = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_addr_d = rd_addr_q;
      if (ena) begin
         if (out_ram_rd) begin
            rd_addr_d = rd_addr_q + AW'(1);
         end else if (start_of_MB) begin
            rd_addr_d = '0;
         end
      end
   end

   assign src_idx = mv_src_idx(blk_q);
   assign fx_sel  = mvx_q[int'(src_idx)*MV_W +: MV_W];
   assign fy_sel  = mvy_q[int'(src_idx)*MV_W +: MV_W];
   assign cb_sel  = blk_q[4] & ~blk_q[2];
   assign cr_sel  = blk_q[4] &  blk_q[2];

   // Idle stages carry zero tags so stage-out fields read 0 between blocks.
   assign tag_in = issue ? {row_q, blk_q, fx_sel, fy_sel, cb_sel, cr_sel} : '0;

   inter_pred_tag_pipe #(
      .DEPTH (PPL_DEPTH),
      .W     (TAG_W)
   ) u_tag_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .vld_i  (issue),
      .tag_i  (tag_in),
      .vld_o  (so_vld),
      .tag_o  (tag_out),
      .busy_o (pipe_busy)
   );

   assign {so_row, so_blk, so_fx, so_fy, so_cb, so_cr} = tag_out;

   always_comb begin
      out_ram_wr = '0;
      if (ena && so_vld) begin
         if (col_sel) begin
            out_ram_wr = 16'h1111 << so_row;
         end else begin
            out_ram_wr = 16'h000F << {so_row, 2'b00};
         end
      end
   end

   assign out_ram_wr_addr = AW'(blk_to_addr(so_blk));
   assign out_ram_rd_addr = rd_addr_q;
   assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_inter_pred_blk_sched.sv
module tb_inter_pred_blk_sched;

   localparam int MV_W = 3;
   localparam int AW   = 5;

   logic               clk = 1'b0;
   logic               rst_n, ena, start, start_m, start_of_MB, col_sel;
   logic               ref_fifo_empty, out_ram_rd;
   logic [16*MV_W-1:0] mvx_frac, mvy_frac;

   logic               ref_fifo_rd_c, busy_c, done_o_c, so_vld_c, so_cb_c, so_cr_c;
   logic [1:0]         so_row_c;
   logic [4:0]         so_blk_c;
   logic [MV_W-1:0]    so_fx_c, so_fy_c;
   logic [15:0]        out_ram_wr_c;
   logic [AW-1:0]      wr_addr_c, rd_addr_c;

   logic               ref_fifo_rd_m, busy_m, done_o_m, so_vld_m, so_cb_m, so_cr_m;
   logic [1:0]         so_row_m;
   logic [4:0]         so_blk_m;
   logic [MV_W-1:0]    so_fx_m, so_fy_m;
   logic [15:0]        out_ram_wr_m;
   logic [AW-1:0]      wr_addr_m, rd_addr_m;

   always #5 clk = ~clk;

   inter_pred_blk_sched #(.PPL_DEPTH(4), .MV_W(MV_W), .CHROMA_EN(1), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .start_of_MB(start_of_MB),
      .col_sel(col_sel), .mvx_frac(mvx_frac), .mvy_frac(mvy_frac),
      .ref_fifo_empty(ref_fifo_empty), .ref_fifo_rd(ref_fifo_rd_c), .busy(busy_c),
      .done(done_o_c), .so_vld(so_vld_c), .so_row(so_row_c), .so_blk(so_blk_c),
      .so_fx(so_fx_c), .so_fy(so_fy_c), .so_cb(so_cb_c), .so_cr(so_cr_c),
      .out_ram_wr(out_ram_wr_c), .out_ram_wr_addr(wr_addr_c),
      .out_ram_rd(out_ram_rd), .out_ram_rd_addr(rd_addr_c));

   inter_pred_blk_sched #(.PPL_DEPTH(4), .MV_W(MV_W), .CHROMA_EN(0), .AW(AW)) dut_mono (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_m), .start_of_MB(start_of_MB),
      .col_sel(col_sel), .mvx_frac(mvx_frac), .mvy_frac(mvy_frac),
      .ref_fifo_empty(ref_fifo_empty), .ref_fifo_rd(ref_fifo_rd_m), .busy(busy_m),
      .done(done_o_m), .so_vld(so_vld_m), .so_row(so_row_m), .so_blk(so_blk_m),
      .so_fx(so_fx_m), .so_fy(so_fy_m), .so_cb(so_cb_m), .so_cr(so_cr_m),
      .out_ram_wr(out_ram_wr_m), .out_ram_wr_addr(wr_addr_m),
      .out_ram_rd(out_ram_rd), .out_ram_rd_addr(rd_addr_m));

   typedef struct packed {
      logic [4:0]  blk;
      logic [1:0]  row;
      logic [2:0]  fx;
      logic [2:0]  fy;
      logic        cb;
      logic        cr;
      logic [15:0] wr;
      logic [4:0]  addr;
   } slot_t;

   slot_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   int    mvx_e[16];
   int    mvy_e[16];
   int    zt[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
   int    qt[4]  = '{0, 2, 8, 10};

   int pops_c, vld_c, done_c, first_pop_c, first_vld_c, last_vld_c, done_cyc_c;
   int run_c, max_run_c, gap_c, n_gaps_c, last_gap_c;
   int pops_m, vld_m, done_m, max_blk_m;
   logic [31:0] cap_wr_b3r2, cap_addr_b3r2, cap_wr_b0r1, fx18, cb18, fx22, cr22;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_c();
      pops_c = 0; vld_c = 0; done_c = 0; first_pop_c = -1; first_vld_c = -1;
      last_vld_c = -1; done_cyc_c = -1; run_c = 0; max_run_c = 0; gap_c = 0;
      n_gaps_c = 0; last_gap_c = 0;
      cap_wr_b3r2 = 32'hdead; cap_addr_b3r2 = 32'hdead; cap_wr_b0r1 = 32'hdead;
      fx18 = 32'hdead; cb18 = 32'hdead; fx22 = 32'hdead; cr22 = 32'hdead;
   endtask

   // Samples both DUTs once per cycle, pops the scoreboard on each stage-out row.
   task automatic mon();
      slot_t e;
      if (rst_n && ena) begin
         if (start && !busy_c) clear_c();
         if (start_m && !busy_m) begin
            pops_m = 0; vld_m = 0; done_m = 0; max_blk_m = 0;
         end
         if (ref_fifo_rd_c) begin
            pops_c++;
            if (first_pop_c < 0) first_pop_c = cyc;
         end
         if (so_vld_c) begin
            vld_c++;
            if (first_vld_c < 0) first_vld_c = cyc;
            last_vld_c = cyc;
            if (gap_c > 0) begin
               n_gaps_c++; last_gap_c = gap_c; gap_c = 0;
            end
            run_c++;
            if (run_c > max_run_c) max_run_c = run_c;
            if (so_blk_c == 5'd3 && so_row_c == 2'd2) begin
               cap_wr_b3r2 = 32'(out_ram_wr_c); cap_addr_b3r2 = 32'(wr_addr_c);
            end
            if (so_blk_c == 5'd0 && so_row_c == 2'd1) cap_wr_b0r1 = 32'(out_ram_wr_c);
            if (so_blk_c == 5'd18 && so_row_c == 2'd0) begin
               fx18 = 32'(so_fx_c); cb18 = 32'(so_cb_c);
            end
            if (so_blk_c == 5'd22 && so_row_c == 2'd0) begin
               fx22 = 32'(so_fx_c); cr22 = 32'(so_cr_c);
            end
            if (exp_q.size() == 0) begin
               check("sb_underflow", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check("so_blk", so_blk_c, e.blk);
               check("so_row", so_row_c, e.row);
               check("so_fx", so_fx_c, e.fx);
               check("so_fy", so_fy_c, e.fy);
               check("so_cb_cr", {so_cb_c, so_cr_c}, {e.cb, e.cr});
               check("out_ram_wr", out_ram_wr_c, e.wr);
               check("out_ram_wr_addr", wr_addr_c, e.addr);
            end
         end else begin
            run_c = 0;
            if (first_vld_c >= 0) gap_c++;
         end
         if (done_o_c) begin
            done_c++; done_cyc_c = cyc;
         end
         if (ref_fifo_rd_m) pops_m++;
         if (so_vld_m) begin
            vld_m++;
            if (int'(so_blk_m) > max_blk_m) max_blk_m = int'(so_blk_m);
         end
         if (done_o_m) done_m++;
      end
   endtask

   // Sample mid-cycle, then return 1 time unit after the next rising edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mv();
      for (int i = 0; i < 16; i++) begin
         mvx_e[i] = int'($urandom_range(0, 7));
         mvy_e[i] = int'($urandom_range(0, 7));
      end
      mvx_e[8] = 5;
      for (int i = 0; i < 16; i++) begin
         mvx_frac[i*MV_W +: MV_W] = MV_W'(mvx_e[i]);
         mvy_frac[i*MV_W +: MV_W] = MV_W'(mvy_e[i]);
      end
   endtask

   task automatic push_mb(input bit cs);
      slot_t e;
      int    src;
      for (int b = 0; b < 24; b++) begin
         for (int r = 0; r < 4; r++) begin
            src    = (b < 16) ? b : qt[(b - 16) % 4];
            e.blk  = 5'(b);
            e.row  = 2'(r);
            e.fx   = 3'(mvx_e[src]);
            e.fy   = 3'(mvy_e[src]);
            e.cb   = (b >= 16 && b < 20);
            e.cr   = (b >= 20);
            e.addr = (b < 16) ? 5'(zt[b]) : 5'(b);
            for (int k = 0; k < 16; k++) begin
               e.wr[k] = cs ? ((k % 4) == r) : ((k / 4) == r);
            end
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic wait_vld(input int target, input int budget);
      int n = 0;
      while (vld_c < target && n < budget) begin
         tick(); n++;
      end
      check("vld_wait", vld_c, target);
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; start = 1'b0; start_m = 1'b0; start_of_MB = 1'b0;
      col_sel = 1'b0; ref_fifo_empty = 1'b0; out_ram_rd = 1'b0;
      mvx_frac = '0; mvy_frac = '0;
      clear_c();
      pops_m = 0; vld_m = 0; done_m = 0; max_blk_m = 0;
      repeat (3) tick();
      check("rst_busy", busy_c, 0);
      check("rst_so_vld", so_vld_c, 0);
      check("rst_done", done_o_c, 0);
      check("rst_fifo_rd", ref_fifo_rd_c, 0);
      check("rst_wr", out_ram_wr_c, 0);
      check("rst_wr_addr", wr_addr_c, 0);
      check("rst_rd_addr", rd_addr_c, 0);
      check("rst_busy_mono", busy_m, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // Run A: FIFO never empty, row-wise lanes; start held in the final DRAIN cycle
      set_mv();
      push_mb(1'b0);
      start = 1'b1; tick(); start = 1'b0;
      wait_vld(96, 300);
      start = 1'b1; tick(); start = 1'b0;
      check("A_done_once", done_c, 1);
      repeat (5) tick();
      check("A_busy_after_done", busy_c, 0);
      check("A_pops", pops_c, 24);
      check("A_vld", vld_c, 96);
      check("A_no_bubble", max_run_c, 96);
      // first issue is the cycle after the first pop; stage-out follows 4 cycles later
      check("A_latency", first_vld_c - first_pop_c, 5);
      check("A_done_delay", done_cyc_c - last_vld_c, 1);
      check("A_sb_empty", exp_q.size(), 0);
      check("A_b3r2_wr", cap_wr_b3r2, 32'h0F00);
      check("A_b3r2_addr", cap_addr_b3r2, 5);
      check("A_b18_fx", fx18, 5);
      check("A_b18_cb", cb18, 1);
      check("A_b22_fx", fx22, 5);
      check("A_b22_cr", cr22, 1);

      // Run B: column-wise lanes, FIFO empty for 3 WAIT cycles after block 5
      set_mv();
      col_sel = 1'b1;
      push_mb(1'b1);
      start = 1'b1; tick(); start = 1'b0;
      for (int n = 0; pops_c < 6 && n < 100; n++) tick();
      check("B_stall_sync", pops_c, 6);
      ref_fifo_empty = 1'b1;
      repeat (4) tick();
      for (int i = 0; i < 3; i++) begin
         check("B_stall_no_pop", ref_fifo_rd_c, 0);
         check("B_stall_busy", busy_c, 1);
         tick();
      end
      ref_fifo_empty = 1'b0;
      wait_vld(96, 300);
      repeat (3) tick();
      check("B_pops", pops_c, 24);
      check("B_gap_count", n_gaps_c, 1);
      check("B_gap_len", last_gap_c, 4);
      check("B_b0r1_wr", cap_wr_b0r1, 32'h2222);
      check("B_done", done_c, 1);
      check("B_sb_empty", exp_q.size(), 0);

      // Run C: monochrome instance, second start during ISSUE
      col_sel = 1'b0;
      start_m = 1'b1; tick(); start_m = 1'b0;
      repeat (10) tick();
      start_m = 1'b1; tick(); start_m = 1'b0;
      for (int n = 0; done_m == 0 && n < 200; n++) tick();
      repeat (10) tick();
      check("C_vld", vld_m, 64);
      check("C_pops", pops_m, 16);
      check("C_done", done_m, 1);
      check("C_max_blk", max_blk_m, 15);
      check("C_busy_after", busy_m, 0);
      check("C_chroma_idle", vld_c, 96);

      // Run D: ena low for 5 cycles while slot 9 (blk 2 row 1) is at stage-out
      push_mb(1'b0);
      start = 1'b1; tick(); start = 1'b0;
      repeat (14) tick();
      ena = 1'b0; out_ram_rd = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         check("D_frz_vld", so_vld_c, 1);
         check("D_frz_blk", so_blk_c, 2);
         check("D_frz_row", so_row_c, 1);
         check("D_frz_addr", wr_addr_c, 4);
         check("D_frz_wr", out_ram_wr_c, 0);
         check("D_frz_fifo_rd", ref_fifo_rd_c, 0);
         check("D_frz_done", done_o_c, 0);
         check("D_frz_rd_addr", rd_addr_c, 0);
         tick();
      end
      ena = 1'b1; out_ram_rd = 1'b0;
      wait_vld(96, 300);
      repeat (3) tick();
      check("D_pops", pops_c, 24);
      check("D_done", done_c, 1);
      check("D_sb_empty", exp_q.size(), 0);

      // Run E: reset mid-block
      push_mb(1'b0);
      start = 1'b1; tick(); start = 1'b0;
      out_ram_rd = 1'b1; repeat (3) tick(); out_ram_rd = 1'b0;
      repeat (16) tick();
      check("E_pre_busy", busy_c, 1);
      check("E_pre_vld", so_vld_c, 1);
      check("E_pre_rd_addr", rd_addr_c, 3);
      #2 rst_n = 1'b0;
      #1;
      check("E_rst_busy", busy_c, 0);
      check("E_rst_vld", so_vld_c, 0);
      check("E_rst_rd_addr", rd_addr_c, 0);
      check("E_rst_wr_addr", wr_addr_c, 0);
      check("E_rst_wr", out_ram_wr_c, 0);
      exp_q.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      check("E_no_done", done_c, 0);
      check("E_idle_busy", busy_c, 0);

      // Run F: read address counter
      out_ram_rd = 1'b1; repeat (7) tick(); out_ram_rd = 1'b0;
      check("F_rd7", rd_addr_c, 7);
      out_ram_rd = 1'b1; start_of_MB = 1'b1; tick();
      out_ram_rd = 1'b0; start_of_MB = 1'b0;
      check("F_rd_prio", rd_addr_c, 8);
      start_of_MB = 1'b1; tick(); start_of_MB = 1'b0;
      check("F_clear", rd_addr_c, 0);
      out_ram_rd = 1'b1; repeat (31) tick();
      check("F_rd31", rd_addr_c, 31);
      tick(); out_ram_rd = 1'b0;
      check("F_wrap", rd_addr_c, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
